// File: rtl/pipe_run_ctrl.sv
// Run-control sequencer for the 8-bit three-stage pipeline: loads instruction memory,
// then starts, halts, drains and single-steps the core. Define PIPE_RUN_CTRL_PERF_EN to
// build the 16-bit retired-instruction counter; otherwise retired is tied to zero.
module pipe_run_ctrl #(
    parameter int IMEM_AW      = 4,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_start,
    input  logic               run_start,
    input  logic               halt_req,
    input  logic               halt_instr,
    input  logic               step_req,
    input  logic               clear_req,
    input  logic               ld_valid,
    input  logic [7:0]         ld_data,
    input  logic               ld_last,
    output logic               ld_ready,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_waddr,
    output logic [7:0]         imem_wdata,
    output logic               pc_en,
    output logic               flush,
    output logic [2:0]         stage_valid,
    output logic [2:0]         state,
    output logic [15:0]        retired
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4,
        ST_STEP   = 3'd5
    } run_state_e;

    // DRAIN_CYCLES must be at least 1; the counter holds values DRAIN_CYCLES..1.
    localparam int                 CNT_W      = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0]   DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);
    localparam logic [IMEM_AW-1:0] ADDR_LAST  = '1;

    run_state_e         state_q;
    run_state_e         state_d;
    logic [IMEM_AW-1:0] load_addr_q;
    logic [IMEM_AW-1:0] load_addr_d;
    logic [CNT_W-1:0]   drain_cnt_q;
    logic [CNT_W-1:0]   drain_cnt_d;
    logic               flush_q;
    logic               flush_d;
    logic               beat;
    logic               load_done;
    logic [2:0]         stage_valid_q;

    // Moore decode from the state register
    assign pc_en    = (state_q == ST_RUN) || (state_q == ST_STEP);
    assign ld_ready = (state_q == ST_LOAD);
    assign beat     = ld_valid && ld_ready;

    // The last writable address ends the load even without ld_last; the address never wraps.
    assign load_done = beat && (ld_last || (load_addr_q == ADDR_LAST));

    assign imem_we    = beat;
    assign imem_waddr = load_addr_q;
    assign imem_wdata = ld_ready ? ld_data : 8'h00;

    assign flush       = flush_q;
    assign state       = state_q;
    assign stage_valid = stage_valid_q;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned
        // and no latch is inferred.
        state_d     = state_q;
        load_addr_d = load_addr_q;
        drain_cnt_d = drain_cnt_q;
        flush_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d     = ST_LOAD;
                    load_addr_d = '0;
                end else if (run_start) begin
                    state_d = ST_RUN;
                end
            end

            ST_LOAD: begin
                if (beat) begin
                    if (load_addr_q != ADDR_LAST) begin
                        load_addr_d = load_addr_q + 1'b1;
                    end
                    if (load_done) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_RUN: begin
                if (halt_req || halt_instr) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end
            end

            ST_DRAIN: begin
                drain_cnt_d = drain_cnt_q - 1'b1;
                if (drain_cnt_q <= CNT_W'(1)) begin
                    state_d = ST_HALTED;
                end
            end

            ST_HALTED: begin
                if (run_start) begin
                    state_d = ST_RUN;
                end else if (step_req) begin
                    state_d = ST_STEP;
                end else if (clear_req) begin
                    state_d = ST_IDLE;
                    flush_d = 1'b1;
                end
            end

            ST_STEP: begin
                state_d     = ST_DRAIN;
                drain_cnt_d = DRAIN_LOAD;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: registers update with non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            load_addr_q <= '0;
            drain_cnt_q <= '0;
            flush_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_addr_q <= load_addr_d;
            drain_cnt_q <= drain_cnt_d;
            flush_q     <= flush_d;
        end
    end

    // Occupancy mirrors the pipeline registers: a fetch enters IF/ID on the edge after pc_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid_q <= 3'b000;
        end else if (flush_q) begin
            stage_valid_q <= 3'b000;
        end else begin
            stage_valid_q <= {stage_valid_q[1:0], pc_en};
        end
    end

`ifdef PIPE_RUN_CTRL_PERF_EN
    logic [15:0] retired_q;

    // One retirement per cycle with EX/WB occupied; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= 16'h0000;
        end else if (flush_q) begin
            retired_q <= 16'h0000;
        end else if (stage_valid_q[2]) begin
            retired_q <= retired_q + 16'd1;
        end
    end

    assign retired = retired_q;
`else
    assign retired = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Self-checking bench for pipe_run_ctrl: directed scenarios plus randomized traffic,
// compared each cycle against a timestamp-based reference model.
module tb_pipe_run_ctrl;

    localparam int IMEM_AW      = 4;
    localparam int DRAIN_CYCLES = 3;
    localparam int DEPTH        = 1 << IMEM_AW;
    localparam int MAXC         = 4096;

    localparam int S_IDLE   = 0;
    localparam int S_LOAD   = 1;
    localparam int S_RUN    = 2;
    localparam int S_DRAIN  = 3;
    localparam int S_HALTED = 4;
    localparam int S_STEP   = 5;

`ifdef PIPE_RUN_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               load_start = 1'b0;
    logic               run_start = 1'b0;
    logic               halt_req = 1'b0;
    logic               halt_instr = 1'b0;
    logic               step_req = 1'b0;
    logic               clear_req = 1'b0;
    logic               ld_valid = 1'b0;
    logic [7:0]         ld_data = 8'h00;
    logic               ld_last = 1'b0;
    logic               ld_ready;
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_waddr;
    logic [7:0]         imem_wdata;
    logic               pc_en;
    logic               flush;
    logic [2:0]         stage_valid;
    logic [2:0]         state;
    logic [15:0]        retired;

    always #5 clk = ~clk;

    pipe_run_ctrl #(
        .IMEM_AW     (IMEM_AW),
        .DRAIN_CYCLES(DRAIN_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .run_start  (run_start),
        .halt_req   (halt_req),
        .halt_instr (halt_instr),
        .step_req   (step_req),
        .clear_req  (clear_req),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .pc_en      (pc_en),
        .flush      (flush),
        .stage_valid(stage_valid),
        .state      (state),
        .retired    (retired)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: run-state per the operating rules, plus a per-cycle fetch log.
    int m_state   = S_IDLE;
    int m_addr    = 0;
    int drain_end = 0;
    int flush_cyc = -1;
    int clr_cyc   = -1;
    int cyc       = 0;
    bit fetch [MAXC];

    logic [7:0] mem_obs [DEPTH];

    always @(posedge clk) begin
        if (rst_n === 1'b1 && imem_we === 1'b1) mem_obs[imem_waddr] <= imem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Bit k holds the instruction fetched k+1 cycles ago, unless a flush/reset came after it.
    function automatic logic [2:0] exp_sv();
        logic [2:0] v = 3'b000;
        for (int k = 0; k < 3; k++) begin
            int f = cyc - 1 - k;
            if (f >= 0 && f > clr_cyc && fetch[f]) v[k] = 1'b1;
        end
        return v;
    endfunction

    // Every fetch since the last clear that reached EX/WB in an earlier cycle has retired.
    function automatic logic [15:0] exp_ret();
        int n = 0;
        if (!PERF) return 16'h0000;
        for (int f = clr_cyc + 1; f <= cyc - 4; f++) if (fetch[f]) n++;
        return 16'(n);
    endfunction

    function automatic bit pct(input int p);
        return $urandom_range(0, 99) < p;
    endfunction

    task automatic step(input bit ls, input bit rs, input bit hr, input bit hi, input bit sr,
                        input bit cr, input bit lv, input logic [7:0] d, input bit ll);
        bit exp_pc;
        @(negedge clk);
        load_start = ls; run_start = rs; halt_req = hr; halt_instr = hi;
        step_req = sr; clear_req = cr; ld_valid = lv; ld_data = d; ld_last = ll;
        #1;
        exp_pc = (m_state == S_RUN) || (m_state == S_STEP);
        check("state", state, m_state);
        check("pc_en", pc_en, exp_pc);
        check("ld_ready", ld_ready, m_state == S_LOAD);
        check("imem_we", imem_we, (m_state == S_LOAD) && lv);
        check("imem_waddr", imem_waddr, m_addr);
        if (m_state == S_LOAD && lv) check("imem_wdata", imem_wdata, d);
        check("flush", flush, cyc == flush_cyc);
        check("stage_valid", stage_valid, exp_sv());
        check("retired", retired, exp_ret());
        if (cyc < MAXC) fetch[cyc] = exp_pc;
        @(posedge clk);
        if (cyc == flush_cyc) clr_cyc = cyc;
        case (m_state)
            S_IDLE: begin
                if (ls) begin
                    m_state = S_LOAD;
                    m_addr  = 0;
                end else if (rs) begin
                    m_state = S_RUN;
                end
            end
            S_LOAD: begin
                if (lv) begin
                    if (ll || m_addr == DEPTH - 1) m_state = S_IDLE;
                    if (m_addr < DEPTH - 1) m_addr++;
                end
            end
            S_RUN: begin
                if (hr || hi) begin
                    m_state   = S_DRAIN;
                    drain_end = cyc + 1 + DRAIN_CYCLES;
                end
            end
            S_DRAIN: begin
                if (cyc + 1 >= drain_end) m_state = S_HALTED;
            end
            S_HALTED: begin
                if (rs) m_state = S_RUN;
                else if (sr) m_state = S_STEP;
                else if (cr) begin
                    m_state   = S_IDLE;
                    flush_cyc = cyc + 1;
                end
            end
            S_STEP: begin
                m_state   = S_DRAIN;
                drain_end = cyc + 1 + DRAIN_CYCLES;
            end
            default: m_state = S_IDLE;
        endcase
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 8'h00, 0);
    endtask

    task automatic req(input bit ls, input bit rs, input bit hr, input bit hi,
                       input bit sr, input bit cr);
        step(ls, rs, hr, hi, sr, cr, 0, 8'h00, 0);
    endtask

    task automatic beat(input logic [7:0] d, input bit ll);
        step(0, 0, 0, 0, 0, 0, 1, d, ll);
    endtask

    // Assert reset mid-cycle; outputs must clear without waiting for a clock edge.
    task automatic reset_mid(input int hold);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        load_start = 0; run_start = 0; halt_req = 0; halt_instr = 0;
        step_req = 0; clear_req = 0; ld_valid = 0; ld_data = 8'h00; ld_last = 0;
        #1;
        check("rst_state", state, 3'd0);
        check("rst_pc_en", pc_en, 1'b0);
        check("rst_ld_ready", ld_ready, 1'b0);
        check("rst_imem_we", imem_we, 1'b0);
        check("rst_imem_waddr", imem_waddr, 0);
        check("rst_imem_wdata", imem_wdata, 8'h00);
        check("rst_flush", flush, 1'b0);
        check("rst_stage_valid", stage_valid, 3'b000);
        check("rst_retired", retired, 16'h0000);
        m_state   = S_IDLE;
        m_addr    = 0;
        flush_cyc = -1;
        if (cyc < MAXC) fetch[cyc] = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            clr_cyc = cyc;
            cyc++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        clr_cyc = cyc;
        cyc++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_load [5];
        exp_load = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        reset_mid(2);

        // Load then run-ready: five beats, ld_last on the fifth.
        req(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) beat(exp_load[i], i == 4);
        #1;
        for (int i = 0; i < 5; i++) check("load_mem", mem_obs[i], exp_load[i]);
        check("load_exit_state", state, 3'd0);
        idle(1);

        // Full-depth load without ld_last, then a stray 17th beat.
        req(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) beat(8'hA0 + 8'(i), 0);
        #1;
        check("full_mem0", mem_obs[0], 8'hA0);
        check("full_mem15", mem_obs[DEPTH-1], 8'hAF);
        check("full_exit_state", state, 3'd0);
        beat(8'hEE, 0);

        // Run for 10 cycles, halt, drain.
        req(0, 1, 0, 0, 0, 0);
        idle(9);
        req(0, 0, 1, 0, 0, 0);
        #1 check("drain_sv0", stage_valid, 3'b111);
        idle(1);
        #1 check("drain_sv1", stage_valid, 3'b110);
        idle(1);
        #1 check("drain_sv2", stage_valid, 3'b100);
        idle(1);
        #1;
        check("halt_sv", stage_valid, 3'b000);
        check("halt_state", state, 3'd4);
        check("halt_retired", retired, PERF ? 16'd10 : 16'd0);

        // Single step from HALTED.
        req(0, 0, 0, 0, 1, 0);
        #1;
        check("step_state", state, 3'd5);
        check("step_pc_en", pc_en, 1'b1);
        idle(1);
        #1 check("step_sv0", stage_valid, 3'b001);
        idle(1);
        #1 check("step_sv1", stage_valid, 3'b010);
        idle(1);
        #1 check("step_sv2", stage_valid, 3'b100);
        idle(1);
        #1;
        check("step_halt_state", state, 3'd4);
        check("step_retired", retired, PERF ? 16'd11 : 16'd0);

        // HALTED with all three requests: run wins; then halt via halt_instr and clear.
        req(0, 1, 0, 0, 1, 1);
        #1 check("prio_halted", state, 3'd2);
        req(0, 0, 0, 1, 0, 0);
        idle(3);
        req(0, 0, 0, 0, 0, 1);
        #1;
        check("clear_flush", flush, 1'b1);
        check("clear_state", state, 3'd0);
        check("clear_retired_hold", retired, PERF ? 16'd12 : 16'd0);
        idle(1);
        #1;
        check("clear_flush_off", flush, 1'b0);
        check("clear_retired", retired, 16'h0000);

        // IDLE with load_start and run_start: load wins; reset at address 3.
        req(1, 1, 0, 0, 0, 0);
        #1 check("prio_idle", state, 3'd1);
        for (int i = 0; i < 3; i++) beat(8'h30 + 8'(i), 0);
        reset_mid(2);
        req(1, 0, 0, 0, 0, 0);
        beat(8'h77, 0);
        #1 check("reload_addr0", mem_obs[0], 8'h77);
        beat(8'h88, 1);

        // Reset during DRAIN.
        req(0, 1, 0, 0, 0, 0);
        idle(4);
        req(0, 0, 1, 0, 0, 0);
        idle(1);
        reset_mid(1);
        idle(2);

        // Randomized traffic with occasional mid-operation resets.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 399) == 0) reset_mid(1 + int'($urandom_range(0, 2)));
            else step(pct(10), pct(10), pct(5), pct(3), pct(15), pct(5), pct(70),
                      8'($urandom), pct(15));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_run_ctrl.md
# pipe_run_ctrl

Run-control sequencer for the 8-bit three-stage pipelined processor (IF/ID, ID/EX and EX/WB registers). It loads the instruction memory through a valid/ready port and starts, halts, drains and single-steps the pipeline. It also tracks a per-stage valid bit and, optionally, counts retired instructions. It sits beside the top-level processor and drives the PC enable, the instruction-memory write port and the pipeline-register flush.

## Interface
- IMEM_AW, default 4: instruction-memory address width; depth is 2^IMEM_AW.
- DRAIN_CYCLES, default 3: cycles needed to empty the pipeline (one per pipeline register).
- Clk  in  1  single clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- load_start  in  1  request to enter LOAD; sampled in IDLE only.
- run_start  in  1  request to run; sampled in IDLE and HALTED.
- halt_req  in  1  halt request; sampled in RUN.
- halt_instr  in  1  decode flag that the fetched instruction is the halt opcode; sampled in RUN.
- step_req  in  1  single-step request; sampled in HALTED.
- clear_req  in  1  return to IDLE with flush; sampled in HALTED.
- ld_valid  in  1  load beat valid.
- ld_data  in  8  instruction byte.
- ld_last  in  1  final beat of the load.
- ld_ready  out  1  load beat accepted.
- imem_we  out  1  instruction-memory write strobe.
- imem_waddr  out  IMEM_AW  write address.
- imem_wdata  out  8  write data.
- pc_en  out  1  PC advance and fetch enable.
- flush  out  1  one-cycle clear of all pipeline registers.
- stage_valid  out  3  bit0 = IF/ID, bit1 = ID/EX, bit2 = EX/WB occupancy.
- state  out  3  encoded state.
- retired  out  16  retired-instruction count.

## Operation
- States and encodings: IDLE=0, LOAD=1, RUN=2, DRAIN=3, HALTED=4, STEP=5.
- IDLE:
  - load_start -> LOAD; the load address clears to 0.
  - Otherwise run_start -> RUN.
  - If both are high, load_start wins.
- LOAD:
  - ld_ready=1.
  - A beat transfers on ld_valid & ld_ready. It produces imem_we=1, imem_waddr = current address, imem_wdata = ld_data in the same cycle. The address then increments.
  - Exit to IDLE after the beat with ld_last=1, or after the beat written at address 2^IMEM_AW−1. The address does not wrap.
- RUN:
  - pc_en=1.
  - halt_req or halt_instr -> DRAIN; the drain counter loads DRAIN_CYCLES.
  - Other inputs are ignored.
- DRAIN:
  - pc_en=0.
  - The counter decrements each cycle; at 1 -> HALTED.
- HALTED:
  - run_start -> RUN.
  - Otherwise step_req -> STEP.
  - Otherwise clear_req -> IDLE with flush=1 for exactly one cycle.
  - Priority: run_start > step_req > clear_req.
- STEP:
  - Lasts exactly one cycle with pc_en=1.
  - Then -> DRAIN with the counter loaded to DRAIN_CYCLES.
- stage_valid:
  - Shifts left every cycle: bit0 <= pc_en, bit1 <= bit0, bit2 <= bit1.
  - flush clears it to 0 in the same edge.
- pc_en, ld_ready and imem_* are Moore outputs decoded from the state register. pc_en=1 exactly in RUN and STEP.

## Timing
- Reset assertion forces, immediately and regardless of Clk: state=IDLE, load address=0, drain counter=0, stage_valid=0, retired=0, pc_en=0, ld_ready=0, imem_we=0, imem_waddr=0, imem_wdata=0, flush=0.
- Reset asserted mid-LOAD or mid-DRAIN abandons the operation; there is no partial resume.
- A request accepted on edge N changes state at edge N; the new state's outputs are valid from edge N to edge N+1.
- Pipeline depth:
  - An instruction fetched with pc_en at cycle N occupies EX/WB (stage_valid[2]=1) in cycle N+3.
  - The last fetch before halt retires in the final DRAIN cycle. stage_valid is 0 on entry to HALTED.
- Step latency: one fetch, then 3 DRAIN cycles; HALTED is re-entered 4 cycles after the STEP state.
- Load throughput is one beat per cycle. A beat with ld_valid=0 leaves the address unchanged.

## Configuration
- PIPE_RUN_CTRL_PERF_EN defined:
  - retired increments on every cycle with stage_valid[2]=1.
  - It wraps 16'hFFFF -> 0 and clears only on reset or flush.
- PIPE_RUN_CTRL_PERF_EN undefined: retired is tied to 16'h0000 and no counter flops are built.

## Test plan
- Load then run:
  - Stimulus: load_start, then 5 beats (0x11, 0x22, 0x33, 0x44, 0x55 with ld_last on 0x55).
  - Required: imem writes to addresses 0–4 with matching data, return to IDLE, and ld_ready=0 afterwards.
- Full-depth load: 16 beats with ld_last never asserted -> exit to IDLE after the address-15 write; a 17th ld_valid gets no ld_ready.
- Run then halt:
  - Stimulus: run_start, then halt_req after 10 RUN cycles.
  - Required: 3 DRAIN cycles, stage_valid sequence 111 -> 110 -> 100 -> 000, state=4, retired=10 (PERF_EN on).
- Single-step: from HALTED, step_req -> one pc_en pulse, stage_valid 001 -> 010 -> 100, back to HALTED, retired +1.
- Simultaneous requests:
  - IDLE with load_start=run_start=1 -> LOAD.
  - HALTED with run_start=step_req=clear_req=1 -> RUN.
- Reset mid-operation: Reset=0 during DRAIN (and again during LOAD at address 3) -> all outputs reach reset values before the next edge; after release, state=IDLE and a subsequent load starts at address 0.
